// File: rtl/reaction_ms_timer.sv
// Reaction timer: random pre-stimulus delay, then a 4-digit BCD millisecond count until stop.
// Optional early-press detection is compiled in when RT_CHEAT_DETECT_EN is defined.
module reaction_ms_timer #(
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    output logic        led,
    output logic        busy,
    output logic [15:0] bcd,
    output logic        done,
    output logic        timeout,
    output logic        cheat
);

    localparam int CNT_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RUN,
        S_DONE,
        S_CHEAT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_lfsr;
    logic               w_lfsr_fb;
    logic [CNT_W-1:0]   r_dly;
    logic [CNT_W-1:0]   w_dly_nxt;
    logic [CNT_W-1:0]   w_dly_load;
    logic [15:0]        r_bcd;
    logic [15:0]        w_bcd_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_tmo;
    logic               w_tmo_nxt;
    logic               r_cheat;
    logic               w_cheat_nxt;
    logic               r_led;
    logic               r_busy;

    // Decimal increment with ripple carry across the four digits; saturation is handled by the caller.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (res[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = res[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_dly_load = CNT_W'(MIN_DELAY_MS) + CNT_W'(r_lfsr[RAND_BITS-1:0]);

    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly;
        w_bcd_nxt   = r_bcd;
        w_done_nxt  = r_done;
        w_tmo_nxt   = r_tmo;
        w_cheat_nxt = r_cheat;
        case (r_state)
            S_IDLE, S_DONE, S_CHEAT: begin
                if (start) begin
                    w_state_nxt = S_WAIT;
                    w_dly_nxt   = w_dly_load;
                    w_bcd_nxt   = 16'h0000;
                    w_done_nxt  = 1'b0;
                    w_tmo_nxt   = 1'b0;
                    w_cheat_nxt = 1'b0;
                end
            end
            S_WAIT: begin
`ifdef RT_CHEAT_DETECT_EN
                if (stop) begin
                    w_state_nxt = S_CHEAT;
                    w_cheat_nxt = 1'b1;
                    w_bcd_nxt   = 16'h9999;
                end else
`endif
                if (tick) begin
                    if (r_dly == CNT_W'(1)) begin
                        w_state_nxt = S_RUN;
                        w_bcd_nxt   = 16'h0000;
                    end else begin
                        w_dly_nxt = r_dly - CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                // A stop in the same cycle as a tick freezes the count before that tick lands.
                if (stop) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else if (tick) begin
                    if (r_bcd == 16'h9999) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_tmo_nxt   = 1'b1;
                    end else begin
                        w_bcd_nxt = bcd_inc(r_bcd);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lfsr  <= 16'hACE1;
            r_dly   <= '0;
            r_bcd   <= 16'h0000;
            r_done  <= 1'b0;
            r_tmo   <= 1'b0;
            r_cheat <= 1'b0;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
            r_dly   <= w_dly_nxt;
            r_bcd   <= w_bcd_nxt;
            r_done  <= w_done_nxt;
            r_tmo   <= w_tmo_nxt;
            r_cheat <= w_cheat_nxt;
            r_led   <= (w_state_nxt == S_RUN);
            r_busy  <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_RUN);
        end
    end

    assign led     = r_led;
    assign busy    = r_busy;
    assign bcd     = r_bcd;
    assign done    = r_done;
    assign timeout = r_tmo;
    assign cheat   = r_cheat;

endmodule

// File: doc/reaction_ms_timer.md
REACTION_MS_TIMER -- requirements
Module: reaction_ms_timer

Interface
REQ-001 SHALL have parameter: MIN_DELAY_MS, 1000, fixed part of the random pre-stimulus delay, in ms ticks (>=1).
REQ-002 SHALL have parameter: RAND_BITS, 11, width of the random delay add-on taken from the LFSR (1..16).
REQ-003 SHALL have ports: clk  in  1  system clock; reset  in  1  synchronous, active-high.
REQ-004 SHALL have port: tick  in  1  1 kHz single-cycle enable pulse from the ms tick generator.
REQ-005 SHALL have ports: start  in  1  debounced single-cycle start request; stop  in  1  debounced single-cycle response button.
REQ-006 SHALL have ports: led  out  1  stimulus lamp; busy  out  1  WAIT or RUN active.
REQ-007 SHALL have ports: bcd  out  16  four BCD digits of elapsed ms, [15:12] thousands .. [3:0] units.
REQ-008 SHALL have ports: done  out  1  valid result held; timeout  out  1  9999 ms reached; cheat  out  1  early press flagged.

Function
REQ-009 SHALL implement FSM states IDLE, WAIT, RUN, DONE, CHEAT; all outputs registered.
REQ-010 SHALL run a 16-bit Fibonacci LFSR every clk cycle: taps 16,14,13,11, shift left, reset value 16'hACE1.
REQ-011 On start in IDLE, DONE or CHEAT: SHALL load delay counter = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], clear bcd/done/timeout/cheat, enter WAIT.
REQ-012 In WAIT: SHALL decrement delay counter by 1 on each tick; on the tick where counter is 1, SHALL enter RUN next cycle with led=1, bcd=16'h0000.
REQ-013 In RUN: each tick SHALL increment bcd as a decimal counter (units 9->0 carries into tens, etc.).
REQ-014 In RUN, stop SHALL enter DONE, led=0, done=1, bcd frozen; stop and tick in same cycle: stop wins, tick not counted.
REQ-015 In RUN, when bcd==16'h9999 and tick: SHALL saturate at 9999 and enter DONE with timeout=1, done=1, led=0.
REQ-016 start during WAIT or RUN SHALL be ignored; start and stop in same cycle in IDLE/DONE/CHEAT: start wins.
REQ-017 stop in IDLE or DONE SHALL be ignored; DONE and CHEAT hold outputs until next start.
REQ-018 busy SHALL be 1 exactly in WAIT and RUN; led SHALL be 1 exactly in RUN.
REQ-019 Delay counter SHALL be wide enough for MIN_DELAY_MS + 2^RAND_BITS - 1 without wrap.

Reset
REQ-020 reset SHALL override all inputs including mid-WAIT/RUN: state IDLE, led=0, busy=0, bcd=16'h0000, done=0, timeout=0, cheat=0, LFSR=16'hACE1.
REQ-021 First cycle after reset deassertion SHALL accept start.

Configuration
REQ-022 Macro RT_CHEAT_DETECT_EN defined: stop in WAIT SHALL enter CHEAT, cheat=1, bcd=16'h9999, done=0, led=0.
REQ-023 RT_CHEAT_DETECT_EN undefined: stop in WAIT SHALL be ignored, CHEAT state unreachable, cheat tied 0.

Verification (MIN_DELAY_MS=2, RAND_BITS=2, tick every 10 clk)
REQ-024 Reset, then start with lfsr[1:0]=1 -> WAIT; led rises after exactly 3 ticks; bcd=0000, busy=1.
REQ-025 In RUN, 37 ticks then stop -> bcd=16'h0037, done=1, led=0, busy=0; further ticks leave bcd unchanged.
REQ-026 In RUN, stop coincident with 10th tick -> bcd=16'h0009; 9 then 10 ticks shows carry 0009->0010.
REQ-027 In RUN, 10000 ticks, no stop -> bcd=16'h9999, timeout=1, done=1; extra ticks keep 9999.
REQ-028 With RT_CHEAT_DETECT_EN: stop in WAIT -> cheat=1, bcd=16'h9999, led never rises; without: stop ignored, RUN entered normally.
REQ-029 reset asserted mid-RUN at bcd=0123 -> next cycle all outputs at reset values; new start runs normally.
